arbitro_rr_param: RTL

ARBITRO_RR_PARAM -- requirements
Module: arbitro_rr_param

---
 rtl/arbitro_rr_param_pkg.sv | 29 ++
 rtl/arbitro_rr_param_if.sv | 27 ++
 rtl/arbitro_rr_param_rr_picker.sv | 36 +++
 rtl/arbitro_rr_param.sv | 133 +++++++++++++
 4 files changed

// File: rtl/arbitro_rr_param_pkg.sv
// rtl/arbitro_rr_param_pkg.sv - shared encodings and helpers for the two-VC round-robin arbiter
package arbitro_rr_param_pkg;

  // One-hot system state driven from the surrounding controller
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } sys_state_e;

  // Policy between the two virtual channels
  typedef enum logic {
    MODE_STRICT = 1'b0,
    MODE_WRR    = 1'b1
  } vc_mode_e;

  // Virtual channel identifier carried alongside each pushed word
  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

  // Index after idx, wrapping at n
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_param_if.sv
// rtl/arbitro_rr_param_if.sv - source/destination FIFO handshake bundle for the arbiter
interface arbitro_rr_param_if #(
  parameter int NUM_CH = 4
) ();

  logic [NUM_CH-1:0]         empty_vc0;
  logic [NUM_CH-1:0]         empty_vc1;
  logic [NUM_CH-1:0]         almost_full;
  logic [NUM_CH-1:0]         pop_vc0;
  logic [NUM_CH-1:0]         pop_vc1;
  logic                      push;
  logic                      push_vc;
  logic [$clog2(NUM_CH)-1:0] push_src;

  // Arbiter side: sees FIFO flags, drives pops and the registered push
  modport master (
    input  empty_vc0, empty_vc1, almost_full,
    output pop_vc0, pop_vc1, push, push_vc, push_src
  );

  // FIFO side: mirror of the arbiter view
  modport slave (
    output empty_vc0, empty_vc1, almost_full,
    input  pop_vc0, pop_vc1, push, push_vc, push_src
  );

endinterface

// File: rtl/arbitro_rr_param_rr_picker.sv
// rtl/arbitro_rr_param_rr_picker.sv - rotating first-requester search starting at a pointer
module rr_picker #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] idx,
  output logic                      any
);

  localparam int IDX_W = $clog2(NUM_CH);

  int         pos;
  logic [IDX_W-1:0] pos_idx;

  // Walk the offsets from farthest to nearest so the last hit is the first requester at or after ptr
  always_comb begin
    grant   = '0;
    idx     = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_CH) pos = pos - NUM_CH;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        idx = pos_idx;
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/arbitro_rr_param.sv
// rtl/arbitro_rr_param.sv - two-VC arbiter with strict or weighted round-robin VC policy
module arbitro_rr_param #(
  parameter int NUM_CH     = 4,
  parameter int VC1_WEIGHT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         state,
  input  logic               mode,
  arbitro_rr_param_if.master bus
);

  import arbitro_rr_param_pkg::*;

  localparam int IDX_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] req0, req1;
  logic [NUM_CH-1:0] gnt0, gnt1;
  logic [IDX_W-1:0]  idx0, idx1;
  logic              any0, any1;
  logic [IDX_W-1:0]  ptr0_q, ptr1_q;
  logic [3:0]        wrr_cnt;
  logic              arb_en;
  logic              sel_valid;
  vc_e               sel_vc;
  logic              grant_valid;
  logic              push_q;
  logic              push_vc_q;
  logic [IDX_W-1:0]  push_src_q;
  logic              in_setup;

  assign req0 = ~bus.empty_vc0;
  assign req1 = ~bus.empty_vc1;

  rr_picker #(.NUM_CH(NUM_CH)) u_pick_vc0 (
    .req   (req0),
    .ptr   (ptr0_q),
    .grant (gnt0),
    .idx   (idx0),
    .any   (any0)
  );

  rr_picker #(.NUM_CH(NUM_CH)) u_pick_vc1 (
    .req   (req1),
    .ptr   (ptr1_q),
    .grant (gnt1),
    .idx   (idx1),
    .any   (any1)
  );

  // Arbitration runs only in IDLE/ACTIVE, outside reset, and with no destination near full
  always_comb begin
    in_setup = (state == ST_RESET) || (state == ST_INIT);
    arb_en   = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !reset && (bus.almost_full == '0);
  end

  // VC selection: strict favours VC0; WRR lets VC1 in once the VC0 run reaches the weight
  always_comb begin
    sel_valid = 1'b0;
    sel_vc    = VC0;
    if (mode == MODE_STRICT) begin
      if (any0) begin
        sel_valid = 1'b1;
        sel_vc    = VC0;
      end else if (any1) begin
        sel_valid = 1'b1;
        sel_vc    = VC1;
      end
    end else begin
      if (any1 && ((wrr_cnt == 4'(VC1_WEIGHT)) || !any0)) begin
        sel_valid = 1'b1;
        sel_vc    = VC1;
      end else if (any0) begin
        sel_valid = 1'b1;
        sel_vc    = VC0;
      end
    end
    grant_valid = arb_en && sel_valid;
  end

  // Pops are combinationally gated so a stall or reset suppresses them in the same cycle
  always_comb begin
    bus.pop_vc0 = (grant_valid && sel_vc == VC0) ? gnt0 : '0;
    bus.pop_vc1 = (grant_valid && sel_vc == VC1) ? gnt1 : '0;
  end

  // Push follows the pop by one cycle; VC and source hold when nothing is pushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_q     <= 1'b0;
      push_vc_q  <= 1'b0;
      push_src_q <= '0;
    end else begin
      push_q <= grant_valid;
      if (grant_valid) begin
        push_vc_q  <= sel_vc;
        push_src_q <= (sel_vc == VC0) ? idx0 : idx1;
      end
    end
  end

  // Per-VC rotation pointers advance past the winner; the other VC's pointer is untouched
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr0_q <= '0;
      ptr1_q <= '0;
    end else if (in_setup) begin
      ptr0_q <= '0;
      ptr1_q <= '0;
    end else if (grant_valid) begin
      if (sel_vc == VC0) ptr0_q <= IDX_W'(next_idx(int'(idx0), NUM_CH));
      else               ptr1_q <= IDX_W'(next_idx(int'(idx1), NUM_CH));
    end
  end

  // Count of VC0 wins while VC1 waits, saturating at the weight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrr_cnt <= '0;
    end else if (in_setup || mode == MODE_STRICT || !any1) begin
      wrr_cnt <= '0;
    end else if (grant_valid && sel_vc == VC1) begin
      wrr_cnt <= '0;
    end else if (grant_valid && sel_vc == VC0 && wrr_cnt != 4'(VC1_WEIGHT)) begin
      wrr_cnt <= wrr_cnt + 4'd1;
    end
  end

  assign bus.push     = push_q;
  assign bus.push_vc  = push_vc_q;
  assign bus.push_src = push_src_q;

endmodule
